// File: rtl/sort_run_builder_if.sv
// Handshake bundle for sort_run_builder: upstream word stream in, sorted run out.
interface sort_run_builder_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/sort_run_builder.sv
// Collects a run of up to DEPTH signed words, keeps them sorted by insertion
// as they arrive, then streams the run out in ascending order.
module sort_run_builder #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  sort_run_builder_if.slave            bus,
  output logic [$clog2(DEPTH+1)-1:0]   run_len
);
  localparam int LW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic {FILL, DRAIN} state_t;
  state_t state;

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic signed [DATA_W-1:0] ins [DEPTH];
  logic signed [DATA_W-1:0] in_s;
  logic signed [DATA_W-1:0] out_data_q;
  logic [LW-1:0]            len_q;
  logic [LW-1:0]            len_inc;
  logic [LW-1:0]            pos;
  logic [IW-1:0]            rd_idx;
  logic [IW-1:0]            rd_nxt;
  logic                     in_ready_q;
  logic                     out_valid_q;
  logic                     out_last_q;
  logic                     accept;
  logic                     xfer;

  assign in_s    = $signed(bus.in_data);
  assign accept  = bus.in_valid && in_ready_q;
  assign xfer    = out_valid_q && bus.out_ready;
  assign len_inc = len_q + 1'b1;
  assign rd_nxt  = rd_idx + 1'b1;

  // Counting entries <= new word yields the stable slot: equal keys stay ahead.
  always_comb begin
    pos = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((LW'(i) < len_q) && (mem[i] <= in_s))
        pos = pos + 1'b1;
    end
    ins[0] = (pos == '0) ? in_s : mem[0];
    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (LW'(i) < pos)
        ins[i] = mem[i];
      else if (LW'(i) == pos)
        ins[i] = in_s;
      else
        ins[i] = mem[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      mem <= ins;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FILL;
      len_q       <= '0;
      rd_idx      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            len_q <= len_inc;
            if (bus.in_last || (len_inc == LW'(DEPTH))) begin
              // Smallest entry is presented from the post-insert image so the
              // first word is valid on the very first DRAIN cycle.
              state       <= DRAIN;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_data_q  <= ins[0];
              out_last_q  <= (len_inc == LW'(1));
            end
          end
        end
        DRAIN: begin
          if (xfer) begin
            if (out_last_q) begin
              state       <= FILL;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              len_q       <= '0;
              rd_idx      <= '0;
            end else begin
              rd_idx     <= rd_nxt;
              out_data_q <= mem[rd_nxt];
              out_last_q <= ((LW'(rd_nxt) + LW'(1)) == len_q);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign run_len       = len_q;
endmodule

// File: tb/tb_sort_run_builder.sv
// Scoreboard bench for sort_run_builder: a stable-sort model queues expected
// words per run; a negedge monitor compares every presented output word.
module tb_sort_run_builder;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [LW-1:0] run_len;
  int unsigned   total = 0;
  int unsigned   bad   = 0;
  bit            rnd   = 1'b0;

  logic signed [DW-1:0] cur [$];
  logic [DW:0]          exp_q [$];

  sort_run_builder_if #(.DATA_W(DW)) bus ();

  sort_run_builder #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .run_len(run_len)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
      check("have_exp", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        check("out_data", 64'(bus.out_data), 64'(exp_q[0][DW-1:0]));
        check("out_last", 64'(bus.out_last), 64'(exp_q[0][DW]));
        if (bus.out_ready)
          void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic model_push(input logic signed [DW-1:0] d, input logic l);
    int unsigned p = 0;
    while (p < cur.size() && cur[p] <= d) p++;
    cur.insert(p, d);
    if (l || cur.size() == DEPTH) begin
      for (int i = 0; i < cur.size(); i++)
        exp_q.push_back({(i == cur.size() - 1), cur[i]});
      cur.delete();
    end
  endtask

  task automatic send(input logic signed [DW-1:0] d, input logic l);
    int unsigned n = 0;
    while (!bus.in_ready && n < 300) begin
      step();
      n++;
    end
    check("in_ready_wait", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    model_push(d, l);
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = DW'($urandom);
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n = 0;
    while (!(exp_q.size() == 0 && bus.in_ready && !bus.out_valid) && n < 300) begin
      step();
      n++;
    end
    check(tag, 64'(exp_q.size() == 0 && bus.in_ready && !bus.out_valid), 64'd1);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cur.delete();
    exp_q.delete();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_run_len",   64'(run_len),       64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cyc;
    int unsigned n;
    int unsigned len;
    int signed   v;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_out_last",  64'(bus.out_last),  64'd0);
    check("reset_out_data",  64'(bus.out_data),  64'd0);
    check("reset_in_ready",  64'(bus.in_ready),  64'd1);
    check("reset_run_len",   64'(run_len),       64'd0);

    // 9,3,7,1,5 -> 1,3,5,7,9 in five drain cycles
    send(9, 0); send(3, 0); send(7, 0); send(1, 0);
    check("a_run_len4", 64'(run_len), 64'd4);
    send(5, 1);
    check("a_run_len5",     64'(run_len),       64'd5);
    check("a_first_drain",  64'(bus.out_valid), 64'd1);
    check("a_in_ready_dr",  64'(bus.in_ready),  64'd0);
    cyc = 0; n = 0;
    while (bus.out_valid && n < 50) begin cyc++; n++; step(); end
    check("a_drain_cycles", 64'(cyc), 64'd5);
    wait_idle("a_idle");

    // DEPTH-word run without in_last, then single word 0
    for (int i = 8; i >= 1; i--) send(DW'(i), 0);
    check("b_full_in_ready",  64'(bus.in_ready),  64'd0);
    check("b_full_run_len",   64'(run_len),       64'd8);
    check("b_full_out_valid", 64'(bus.out_valid), 64'd1);
    send(0, 1);
    wait_idle("b_idle");

    // signed order with duplicates
    send(-2, 0); send(4, 0); send(-2, 0); send(0, 1);
    wait_idle("c_idle");

    // output stall 1,0,0,1
    send(6, 0); send(2, 1);
    bus.out_ready = 1'b1; step();
    bus.out_ready = 1'b0; step();
    step();
    bus.out_ready = 1'b1; step();
    wait_idle("d_idle");

    // reset after the 2nd word accepted
    send(10, 0); send(20, 0);
    pulse_reset();
    send(4, 0); send(1, 1);
    wait_idle("e1_idle");

    // reset after the 1st word drained
    bus.out_ready = 1'b0;
    send(5, 0); send(7, 1);
    bus.out_ready = 1'b1; step();
    bus.out_ready = 1'b0;
    pulse_reset();
    bus.out_ready = 1'b1;
    send(4, 0); send(1, 1);
    wait_idle("e2_idle");

    // single word run
    send(42, 1);
    check("f_single_last", 64'(bus.out_last), 64'd1);
    wait_idle("f_idle");

    // signed extremes
    send(32'sh7fffffff, 0); send(32'sh80000000, 0); send(0, 0); send(-1, 1);
    wait_idle("g_idle");

    // random runs, some longer than DEPTH, with random backpressure
    rnd = 1'b1;
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 11);
      for (int unsigned k = 0; k < len; k++) begin
        v = int'($urandom_range(0, 20)) - 10;
        send(DW'(v), k == len - 1);
      end
    end
    wait_idle("h_idle");
    rnd = 1'b0;
    bus.out_ready = 1'b1;

    check("leftover", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
